// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with 2-flop input synchroniser, 3-sample majority vote,
// start-glitch rejection and parity / framing / break reporting.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int unsigned DBIT      = 8,
  parameter int unsigned OVS       = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            busy
);

  localparam int unsigned   SW          = $clog2(OVS);
  localparam int unsigned   NW          = $clog2(DBIT);
  localparam logic [SW-1:0] S_SMP0      = SW'(OVS / 32'd2 - 32'd1);
  localparam logic [SW-1:0] S_SMP1      = SW'(OVS / 32'd2);
  localparam logic [SW-1:0] S_VOTE      = SW'(OVS / 32'd2 + 32'd1);
  localparam logic [SW-1:0] S_LAST      = SW'(OVS - 32'd1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 32'd1);
  localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 32'd1);
  localparam logic          PAR_EN      = (PARITY != 32'd0);
  localparam logic          PAR_ODD     = (PARITY == 32'd2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic            smp0_q, smp0_d, smp1_q, smp1_d, bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d, dout_q, dout_d;
  logic            par_bit_q, par_bit_d, perr_pend_q, perr_pend_d, ferr_pend_q, ferr_pend_d;
  logic            done_q, done_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d, busy_q, busy_d;
  logic            vote, ev_vote, ev_last, in_frame, is_break;

  // Next-state and datapath for the receiver
  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    s_d         = s_q;
    n_d         = n_q;
    smp0_d      = smp0_q;
    smp1_d      = smp1_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    dout_d      = dout_q;
    par_bit_d   = par_bit_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    done_d      = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    brk_d       = brk_q;

    in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
               (state_q == ST_PARITY) || (state_q == ST_STOP);
    vote     = maj3(smp0_q, smp1_q, rx_s_q);
    ev_vote  = in_frame && s_tick && (s_q == S_VOTE);
    ev_last  = in_frame && s_tick && (s_q == S_LAST);
    is_break = (n_q == '0) && (shreg_q == '0) && !par_bit_q && !vote;

    if (in_frame && s_tick) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      case (s_q)
        S_SMP0:  smp0_d = rx_s_q;
        S_SMP1:  smp1_d = rx_s_q;
        default: smp0_d = smp0_q;
      endcase
    end else begin
      s_d = s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d     = ST_START;
          s_d         = '0;
          n_d         = '0;
          par_bit_d   = 1'b0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // A start bit that votes high mid-bit was only a glitch
        if (ev_vote && vote) begin
          state_d = ST_IDLE;
          s_d     = '0;
        end else if (ev_last) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (ev_vote) begin
          bit_d = vote;
        end else if (ev_last) begin
          shreg_d = {bit_q, shreg_q[DBIT-1:1]};
          n_d     = (n_q == N_LAST) ? '0 : n_q + NW'(1);
          state_d = (n_q != N_LAST) ? ST_DATA : (PAR_EN ? ST_PARITY : ST_STOP);
        end else begin
          bit_d = bit_q;
        end
      end
      ST_PARITY: begin
        if (ev_vote) begin
          par_bit_d   = vote;
          perr_pend_d = ((^shreg_q) ^ vote) != PAR_ODD;
        end else if (ev_last) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        // Frames end mid-way through the last stop bit so back-to-back starts are caught
        if (ev_vote) begin
          if (is_break) begin
            state_d = ST_BREAK;
            done_d  = 1'b1;
            dout_d  = '0;
            perr_d  = perr_pend_q;
            ferr_d  = 1'b1;
            brk_d   = 1'b1;
            s_d     = '0;
            n_d     = '0;
          end else if (n_q == N_STOP_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            dout_d  = shreg_q;
            perr_d  = perr_pend_q;
            ferr_d  = ferr_pend_q | ~vote;
            brk_d   = 1'b0;
            s_d     = '0;
            n_d     = '0;
          end else begin
            ferr_pend_d = ferr_pend_q | ~vote;
          end
        end else if (ev_last) begin
          n_d = n_q + NW'(1);
        end else begin
          n_d = n_q;
        end
      end
      ST_BREAK: state_d = rx_s_q ? ST_IDLE : ST_BREAK;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, synchroniser and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      s_q         <= '0;
      n_q         <= '0;
      smp0_q      <= 1'b0;
      smp1_q      <= 1'b0;
      bit_q       <= 1'b0;
      shreg_q     <= '0;
      dout_q      <= '0;
      par_bit_q   <= 1'b0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      s_q         <= s_d;
      n_q         <= n_d;
      smp0_q      <= smp0_d;
      smp1_q      <= smp1_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      par_bit_q   <= par_bit_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
      busy_q      <= busy_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign break_det    = brk_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances driven by hand-built frames.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx_v     [3];
  logic [7:0] dout_a   [3];
  logic       done_a   [3];
  logic       pe_a     [3];
  logic       fe_a     [3];
  logic       bk_a     [3];
  logic       busy_a   [3];

  int         cnt_a    [3] = '{0, 0, 0};
  int         dbl_a    [3] = '{0, 0, 0};
  logic       prev_done[3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] cap_dout [3];
  logic [2:0] cap_flags[3];
  logic       cap_busy [3];

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_cfg #(.DBIT(8), .OVS(16), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .rx(rx_v[0]), .s_tick(s_tick), .dout(dout_a[0]),
    .rx_done_tick(done_a[0]), .parity_err(pe_a[0]), .frame_err(fe_a[0]),
    .break_det(bk_a[0]), .busy(busy_a[0]));

  uart_rx_cfg #(.DBIT(8), .OVS(16), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .rx(rx_v[1]), .s_tick(s_tick), .dout(dout_a[1]),
    .rx_done_tick(done_a[1]), .parity_err(pe_a[1]), .frame_err(fe_a[1]),
    .break_det(bk_a[1]), .busy(busy_a[1]));

  uart_rx_cfg #(.DBIT(8), .OVS(16), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .reset(reset), .rx(rx_v[2]), .s_tick(s_tick), .dout(dout_a[2]),
    .rx_done_tick(done_a[2]), .parity_err(pe_a[2]), .frame_err(fe_a[2]),
    .break_det(bk_a[2]), .busy(busy_a[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one clk high every second clk
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk) s_tick = 1'b1;
      @(negedge clk) s_tick = 1'b0;
    end
  end

  // Capture every completed frame and catch multi-cycle done pulses
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_a[i] === 1'b1) begin
        cnt_a[i]     <= cnt_a[i] + 1;
        cap_dout[i]  <= dout_a[i];
        cap_flags[i] <= {pe_a[i], fe_a[i], bk_a[i]};
        cap_busy[i]  <= busy_a[i];
        if (prev_done[i] === 1'b1) dbl_a[i] <= dbl_a[i] + 1;
      end
      prev_done[i] <= done_a[i];
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic bit_out(input int idx, input logic b, input bit spike);
    if (spike) begin
      rx_v[idx] = b;  wait_ticks(8);
      rx_v[idx] = ~b; wait_ticks(1);
      rx_v[idx] = b;  wait_ticks(7);
    end else begin
      rx_v[idx] = b;  wait_ticks(16);
    end
  endtask

  task automatic send_frame(input int idx, input logic [7:0] data, input bit has_par,
                            input logic par, input logic [1:0] stops, input int nstop,
                            input int spike_bit);
    bit_out(idx, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(idx, data[i], spike_bit == i);
    if (has_par) bit_out(idx, par, 1'b0);
    for (int i = 0; i < nstop; i++) bit_out(idx, stops[i], 1'b0);
    rx_v[idx] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) rx_v[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({dout_a[i], done_a[i], pe_a[i], fe_a[i], bk_a[i], busy_a[i]} !== 13'h0000) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got dout=%h done=%b pe=%b fe=%b bk=%b busy=%b, expected all 0",
                 i, dout_a[i], done_a[i], pe_a[i], fe_a[i], bk_a[i], busy_a[i]);
      end
    end
    @(negedge clk) reset = 1'b1;
    wait_ticks(4);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({busy_a[i], done_a[i]} !== 2'b00) begin
        n_bad++;
        $display("FAIL idle_after_reset[%0d]: got busy=%b done=%b, expected 0 0", i, busy_a[i], done_a[i]);
      end
    end
  endtask

  task automatic test_8n1();
    int base;
    base = cnt_a[0];
    send_frame(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1, -1);
    n_cmp++;
    if (cnt_a[0] !== base + 1) begin
      n_bad++;
      $display("FAIL 8n1_count: got %0d pulses, expected 1", cnt_a[0] - base);
    end
    n_cmp++;
    if ({cap_dout[0], cap_flags[0], cap_busy[0]} !== {8'hA5, 3'b000, 1'b0}) begin
      n_bad++;
      $display("FAIL 8n1_a5: got dout=%h pe/fe/bk=%b busy=%b, expected a5 000 0",
               cap_dout[0], cap_flags[0], cap_busy[0]);
    end
  endtask

  task automatic test_parity();
    int base;
    base = cnt_a[1];
    send_frame(1, 8'h03, 1'b1, 1'b0, 2'b11, 1, -1);
    n_cmp++;
    if ({cap_dout[1], cap_flags[1]} !== {8'h03, 3'b000} || cnt_a[1] !== base + 1) begin
      n_bad++;
      $display("FAIL 8e1_good_parity: got dout=%h pe/fe/bk=%b pulses=%0d, expected 03 000 1",
               cap_dout[1], cap_flags[1], cnt_a[1] - base);
    end
    send_frame(1, 8'h03, 1'b1, 1'b1, 2'b11, 1, -1);
    n_cmp++;
    if ({cap_dout[1], cap_flags[1]} !== {8'h03, 3'b100} || cnt_a[1] !== base + 2) begin
      n_bad++;
      $display("FAIL 8e1_bad_parity: got dout=%h pe/fe/bk=%b pulses=%0d, expected 03 100 2",
               cap_dout[1], cap_flags[1], cnt_a[1] - base);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = cnt_a[0];
    rx_v[0] = 1'b0;
    wait_ticks(4);
    n_cmp++;
    if (busy_a[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_high: got busy=%b, expected 1", busy_a[0]);
    end
    wait_ticks(2);
    rx_v[0] = 1'b1;
    wait_ticks(20);
    n_cmp++;
    if ({cnt_a[0] == base, busy_a[0], dout_a[0], pe_a[0], fe_a[0], bk_a[0]} !== {1'b1, 1'b0, 8'hA5, 3'b000}) begin
      n_bad++;
      $display("FAIL glitch_reject: got pulses=%0d busy=%b dout=%h pe=%b fe=%b bk=%b, expected 0 0 a5 0 0 0",
               cnt_a[0] - base, busy_a[0], dout_a[0], pe_a[0], fe_a[0], bk_a[0]);
    end
    send_frame(0, 8'h81, 1'b0, 1'b0, 2'b11, 1, 0);
    n_cmp++;
    if ({cap_dout[0], cap_flags[0]} !== {8'h81, 3'b000} || cnt_a[0] !== base + 1) begin
      n_bad++;
      $display("FAIL spike_vote: got dout=%h pe/fe/bk=%b pulses=%0d, expected 81 000 1",
               cap_dout[0], cap_flags[0], cnt_a[0] - base);
    end
  endtask

  task automatic test_stop_bits();
    int base;
    base = cnt_a[2];
    send_frame(2, 8'hC3, 1'b0, 1'b0, 2'b11, 2, -1);
    n_cmp++;
    if ({cap_dout[2], cap_flags[2], cap_busy[2]} !== {8'hC3, 3'b000, 1'b0} || cnt_a[2] !== base + 1) begin
      n_bad++;
      $display("FAIL 8n2_clean: got dout=%h pe/fe/bk=%b busy=%b pulses=%0d, expected c3 000 0 1",
               cap_dout[2], cap_flags[2], cap_busy[2], cnt_a[2] - base);
    end
    send_frame(2, 8'h3C, 1'b0, 1'b0, 2'b01, 2, -1);
    n_cmp++;
    if ({cap_dout[2], cap_flags[2]} !== {8'h3C, 3'b010} || cnt_a[2] !== base + 2) begin
      n_bad++;
      $display("FAIL 8n2_stop2_low: got dout=%h pe/fe/bk=%b pulses=%0d, expected 3c 010 2",
               cap_dout[2], cap_flags[2], cnt_a[2] - base);
    end
  endtask

  task automatic test_break();
    int base;
    base = cnt_a[0];
    rx_v[0] = 1'b0;
    wait_ticks(480);
    n_cmp++;
    if ({cap_dout[0], cap_flags[0], cap_busy[0]} !== {8'h00, 3'b011, 1'b1} || cnt_a[0] !== base + 1) begin
      n_bad++;
      $display("FAIL break_detect: got dout=%h pe/fe/bk=%b busy=%b pulses=%0d, expected 00 011 1 1",
               cap_dout[0], cap_flags[0], cap_busy[0], cnt_a[0] - base);
    end
    n_cmp++;
    if (busy_a[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL break_hold: got busy=%b while line low, expected 1", busy_a[0]);
    end
    rx_v[0] = 1'b1;
    wait_ticks(20);
    n_cmp++;
    if (busy_a[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL break_release: got busy=%b after line high, expected 0", busy_a[0]);
    end
    send_frame(0, 8'h5A, 1'b0, 1'b0, 2'b11, 1, -1);
    n_cmp++;
    if ({cap_dout[0], cap_flags[0]} !== {8'h5A, 3'b000} || cnt_a[0] !== base + 2) begin
      n_bad++;
      $display("FAIL after_break_5a: got dout=%h pe/fe/bk=%b pulses=%0d, expected 5a 000 2",
               cap_dout[0], cap_flags[0], cnt_a[0] - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = cnt_a[0];
    send_frame(0, 8'h00, 1'b0, 1'b0, 2'b11, 1, -1);
    n_cmp++;
    if ({cap_dout[0], cap_flags[0]} !== {8'h00, 3'b000} || cnt_a[0] !== base + 1) begin
      n_bad++;
      $display("FAIL b2b_first_00: got dout=%h pe/fe/bk=%b pulses=%0d, expected 00 000 1",
               cap_dout[0], cap_flags[0], cnt_a[0] - base);
    end
    send_frame(0, 8'hFF, 1'b0, 1'b0, 2'b11, 1, -1);
    n_cmp++;
    if ({cap_dout[0], cap_flags[0]} !== {8'hFF, 3'b000} || cnt_a[0] !== base + 2) begin
      n_bad++;
      $display("FAIL b2b_second_ff: got dout=%h pe/fe/bk=%b pulses=%0d, expected ff 000 2",
               cap_dout[0], cap_flags[0], cnt_a[0] - base);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = cnt_a[0];
    rx_v[0] = 1'b0;
    wait_ticks(16);
    rx_v[0] = 1'b1;
    wait_ticks(48);
    n_cmp++;
    if (busy_a[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_frame_busy: got busy=%b, expected 1", busy_a[0]);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({dout_a[i], done_a[i], pe_a[i], fe_a[i], bk_a[i], busy_a[i]} !== 13'h0000) begin
        n_bad++;
        $display("FAIL async_reset[%0d]: got dout=%h done=%b pe=%b fe=%b bk=%b busy=%b, expected all 0",
                 i, dout_a[i], done_a[i], pe_a[i], fe_a[i], bk_a[i], busy_a[i]);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    wait_ticks(200);
    n_cmp++;
    if ({cnt_a[0] == base, busy_a[0], dout_a[0]} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL no_pulse_after_reset: got pulses=%0d busy=%b dout=%h, expected 0 0 00",
               cnt_a[0] - base, busy_a[0], dout_a[0]);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dbl_a[i] !== 0) begin
        n_bad++;
        $display("FAIL done_one_cycle[%0d]: got %0d multi-cycle pulses, expected 0", i, dbl_a[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_stop_bits();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
